// File: rtl/seq_shifter_pkg.sv
// seq_shifter_pkg: shared CPU definitions used by the sequential shifter.
// Holds the shift/rotate op encoding, x86 flag bit positions and the
// shifter control-state encoding.
package seq_shifter_pkg;

  typedef enum logic [2:0] {
    OP_SHL = 3'd0,
    OP_SHR = 3'd1,
    OP_SAR = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4,
    OP_RCL = 3'd5,
    OP_RCR = 3'd6
  } ShiftOp_t;

  localparam int CF_IDX = 0;
  localparam int PF_IDX = 2;
  localparam int AF_IDX = 4;
  localparam int ZF_IDX = 6;
  localparam int SF_IDX = 7;
  localparam int OF_IDX = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shifter_state_t;

endpackage

// File: rtl/seq_shifter_if.sv
// seq_shifter_if: request/result bundle of the sequential shifter.
// master: requester drives start/op/is_8_bit/a/count/flags_in, sees busy/done/out/flags_out.
// slave : shifter side, opposite directions.
interface seq_shifter_if #(
  parameter int WIDTH      = 16,
  parameter int COUNT_BITS = 8
);
  import seq_shifter_pkg::*;

  logic                  start;
  ShiftOp_t              op;
  logic                  is_8_bit;
  logic [WIDTH-1:0]      a;
  logic [COUNT_BITS-1:0] count;
  logic [15:0]           flags_in;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      out;
  logic [15:0]           flags_out;

  modport master (
    output start, op, is_8_bit, a, count, flags_in,
    input  busy, done, out, flags_out
  );

  modport slave (
    input  start, op, is_8_bit, a, count, flags_in,
    output busy, done, out, flags_out
  );

endinterface

// File: rtl/seq_shifter_shift_step.sv
// shift_step: one single-bit shift/rotate step, purely combinational.
// Latency: 0 cycles. Backpressure: none (no handshake).
// Ports: opnd/cf_in/op/is_8_bit in -> opnd_nxt/cf_nxt out. In 8-bit mode
// only opnd[7:0] participates and opnd_nxt[WIDTH-1:8] is zero.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] opnd,
  input  logic             cf_in,
  input  ShiftOp_t         op,
  input  logic             is_8_bit,
  output logic [WIDTH-1:0] opnd_nxt,
  output logic             cf_nxt
);

  logic [7:0]       w8, r8;
  logic [WIDTH-1:0] wn, rn;
  logic             c8, cn;

  always_comb begin
    w8 = opnd[7:0];
    wn = opnd;
    r8 = w8;
    rn = wn;
    c8 = cf_in;
    cn = cf_in;
    case (op)
      OP_SHL: begin
        r8 = {w8[6:0], 1'b0};          c8 = w8[7];
        rn = {wn[WIDTH-2:0], 1'b0};    cn = wn[WIDTH-1];
      end
      OP_SHR: begin
        r8 = {1'b0, w8[7:1]};          c8 = w8[0];
        rn = {1'b0, wn[WIDTH-1:1]};    cn = wn[0];
      end
      OP_SAR: begin
        r8 = {w8[7], w8[7:1]};         c8 = w8[0];
        rn = {wn[WIDTH-1], wn[WIDTH-1:1]}; cn = wn[0];
      end
      OP_ROL: begin
        r8 = {w8[6:0], w8[7]};         c8 = w8[7];
        rn = {wn[WIDTH-2:0], wn[WIDTH-1]}; cn = wn[WIDTH-1];
      end
      OP_ROR: begin
        r8 = {w8[0], w8[7:1]};         c8 = w8[0];
        rn = {wn[0], wn[WIDTH-1:1]};   cn = wn[0];
      end
      // Rotate-through-carry: CF acts as an extra operand bit.
      OP_RCL: begin
        r8 = {w8[6:0], cf_in};         c8 = w8[7];
        rn = {wn[WIDTH-2:0], cf_in};   cn = wn[WIDTH-1];
      end
      OP_RCR: begin
        r8 = {cf_in, w8[7:1]};         c8 = w8[0];
        rn = {cf_in, wn[WIDTH-1:1]};   cn = wn[0];
      end
      default: ;  // unused encoding: operand and CF pass through
    endcase

    if (is_8_bit) begin
      opnd_nxt = WIDTH'(r8);
      cf_nxt   = c8;
    end else begin
      opnd_nxt = rn;
      cf_nxt   = cn;
    end
  end

endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle x86-style shift/rotate unit, one bit per cycle.
// Latency: done in cycle N+1 after an accepted start (count N; N=0 -> cycle 1).
// Backpressure: start is only sampled in IDLE and never while reset is high.
// Ports: clk, reset (sync, active-high), bus (seq_shifter_if.slave).
// Build option: SHIFT_COUNT_MASK_EN masks the count to count[4:0] (80186);
// without it the full COUNT_BITS count is used (8086).
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int COUNT_BITS = 8
) (
  input  logic           clk,
  input  logic           reset,
  seq_shifter_if.slave   bus
);

  shifter_state_t        state;
  ShiftOp_t              op_q;
  logic                  is8_q;
  logic [WIDTH-1:0]      opnd_q;
  logic                  cf_q;
  logic                  msb_q;     // operand MSB before the first step (SHR OF)
  logic [COUNT_BITS-1:0] rem_q;
  logic [15:0]           flags_q;

  logic                  busy_q, done_q;
  logic [WIDTH-1:0]      out_q;
  logic [15:0]           flags_out_q;

  logic [COUNT_BITS-1:0] eff_cnt;
  logic [WIDTH-1:0]      a_in;
  logic [WIDTH-1:0]      step_opnd;
  logic                  step_cf;
  logic                  res_msb, res_msb1;
  logic [15:0]           flags_res;

`ifdef SHIFT_COUNT_MASK_EN
  assign eff_cnt = COUNT_BITS'(bus.count[4:0]);
`else
  assign eff_cnt = bus.count;
`endif

  // In 8-bit mode the upper operand bits are dropped at latch time so the
  // step datapath and ZF never see them.
  assign a_in = bus.is_8_bit ? WIDTH'(bus.a[7:0]) : bus.a;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .opnd     (opnd_q),
    .cf_in    (cf_q),
    .op       (op_q),
    .is_8_bit (is8_q),
    .opnd_nxt (step_opnd),
    .cf_nxt   (step_cf)
  );

  // Flags for the result of the final step.
  always_comb begin
    res_msb   = is8_q ? step_opnd[7] : step_opnd[WIDTH-1];
    res_msb1  = is8_q ? step_opnd[6] : step_opnd[WIDTH-2];
    flags_res = flags_q;
    flags_res[CF_IDX] = step_cf;
    case (op_q)
      OP_SHL, OP_SHR, OP_SAR: begin
        flags_res[SF_IDX] = res_msb;
        flags_res[ZF_IDX] = (step_opnd == '0);
        flags_res[PF_IDX] = ~^step_opnd[7:0];
        flags_res[AF_IDX] = 1'b0;
      end
      default: ;
    endcase
    case (op_q)
      OP_SHL, OP_ROL, OP_RCL: flags_res[OF_IDX] = res_msb ^ step_cf;
      OP_SHR:                 flags_res[OF_IDX] = msb_q;
      OP_SAR:                 flags_res[OF_IDX] = 1'b0;
      OP_ROR, OP_RCR:         flags_res[OF_IDX] = res_msb ^ res_msb1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      op_q        <= OP_SHL;
      is8_q       <= 1'b0;
      opnd_q      <= '0;
      cf_q        <= 1'b0;
      msb_q       <= 1'b0;
      rem_q       <= '0;
      flags_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_q       <= '0;
      flags_out_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            is8_q   <= bus.is_8_bit;
            opnd_q  <= a_in;
            cf_q    <= bus.flags_in[CF_IDX];
            msb_q   <= bus.is_8_bit ? bus.a[7] : bus.a[WIDTH-1];
            rem_q   <= eff_cnt;
            flags_q <= bus.flags_in;
            busy_q  <= 1'b1;
            if (eff_cnt == '0) begin
              out_q       <= a_in;
              flags_out_q <= bus.flags_in;
              done_q      <= 1'b1;
              state       <= ST_DONE;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          opnd_q <= step_opnd;
          cf_q   <= step_cf;
          rem_q  <= rem_q - COUNT_BITS'(1);
          // Last step: publish the step result directly so done lands in cycle N+1.
          if (rem_q == COUNT_BITS'(1)) begin
            out_q       <= step_opnd;
            flags_out_q <= flags_res;
            done_q      <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out       = out_q;
  assign bus.flags_out = flags_out_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed-vector self-checking bench for seq_shifter.
// Each vector pulses start and measures the done cycle, out and flags_out
// against hand-computed values; also covers start-while-busy and mid-op reset.
module tb_seq_shifter;
  import seq_shifter_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  seq_shifter_if #(.WIDTH(16), .COUNT_BITS(8)) bus ();

  seq_shifter #(.WIDTH(16), .COUNT_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input ShiftOp_t op, input logic is8, input logic [15:0] a,
                       input logic [7:0] cnt, input logic [15:0] fin);
    bus.op       = op;
    bus.is_8_bit = is8;
    bus.a        = a;
    bus.count    = cnt;
    bus.flags_in = fin;
  endtask

  // Pulse start for one cycle, then wait (bounded) for done.
  // Cycle 1 is the cycle right after the edge that accepted start.
  task automatic run_op(input string tag, input ShiftOp_t op, input logic is8,
                        input logic [15:0] a, input logic [7:0] cnt, input logic [15:0] fin,
                        input int exp_cyc, input logic [15:0] exp_out, input logic [15:0] exp_flags);
    int cyc;
    drive(op, is8, a, cnt, fin);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_cycle"}, cyc, exp_cyc);
    chk({tag, "_out"}, bus.out, exp_out);
    chk({tag, "_flags"}, bus.flags_out, exp_flags);
    chk({tag, "_busy_at_done"}, bus.busy, 1'b1);
    @(posedge clk); #1;  // back to IDLE
  endtask

  initial begin
    int n_done;
    bus.start = 1'b0;
    drive(OP_SHL, 1'b0, 16'h0, 8'h0, 16'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  bus.busy, 1'b0);
    chk("rst_done",  bus.done, 1'b0);
    chk("rst_out",   bus.out, 16'h0);
    chk("rst_flags", bus.flags_out, 16'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // tag, op, is8, a, count, flags_in, done cycle, out, flags_out
    run_op("shl1",   OP_SHL, 1'b0, 16'h8001, 8'd1,  16'h0000, 2,  16'h0002, 16'h0801);
    run_op("sar8",   OP_SAR, 1'b1, 16'h0080, 8'd3,  16'h0000, 4,  16'h00F0, 16'h0084);
    run_op("rcr2",   OP_RCR, 1'b0, 16'h0001, 8'd2,  16'h0000, 3,  16'h8000, 16'h0800);
    run_op("rcr3",   OP_RCR, 1'b0, 16'h0001, 8'd3,  16'h0000, 4,  16'h4000, 16'h0800);
    run_op("cnt0",   OP_SHL, 1'b0, 16'h1234, 8'd0,  16'h0F55, 1,  16'h1234, 16'h0F55);
`ifdef SHIFT_COUNT_MASK_EN
    run_op("shr33",  OP_SHR, 1'b0, 16'hFFFF, 8'h21, 16'h0000, 2,  16'h7FFF, 16'h0805);
`else
    run_op("shr33",  OP_SHR, 1'b0, 16'hFFFF, 8'h21, 16'h0000, 34, 16'h0000, 16'h0844);
`endif
    run_op("rol8",   OP_ROL, 1'b1, 16'hAB81, 8'd1,  16'h00D4, 2,  16'h0003, 16'h08D5);
    run_op("ror17",  OP_ROR, 1'b0, 16'h0001, 8'd17, 16'h0000, 18, 16'h8000, 16'h0801);
    run_op("rcl1",   OP_RCL, 1'b0, 16'h8000, 8'd1,  16'h0001, 2,  16'h0001, 16'h0801);
    run_op("shl20",  OP_SHL, 1'b0, 16'hFFFF, 8'd20, 16'h0700, 21, 16'h0000, 16'h0744);

    // start held high throughout: operand changes while busy and the
    // request still present in the DONE cycle must both be ignored.
    drive(OP_SHR, 1'b0, 16'h00F0, 8'd2, 16'h0000);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.a = 16'hFFFF;
    begin
      int cyc = 1;
      while (!bus.done && cyc < 50) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("hold_cycle", cyc, 3);
    end
    chk("hold_out", bus.out, 16'h003C);
    @(posedge clk); #1;
    chk("hold_idle_after_done", bus.busy, 1'b0);
    bus.start = 1'b0;
    @(posedge clk); #1;

    // Reset in cycle 3 of a 10-step op, with a count-0 start also presented.
    drive(OP_SHL, 1'b0, 16'h0001, 8'd10, 16'h0000);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.count = 8'd0;
    @(posedge clk); #1;
    chk("mid_rst_busy",  bus.busy, 1'b0);
    chk("mid_rst_done",  bus.done, 1'b0);
    chk("mid_rst_out",   bus.out, 16'h0);
    chk("mid_rst_flags", bus.flags_out, 16'h0);
    reset     = 1'b0;
    bus.start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) n_done++;
    end
    chk("mid_rst_no_done", n_done, 0);
    chk("mid_rst_idle", bus.busy, 1'b0);
    run_op("after_rst", OP_SHL, 1'b0, 16'h8001, 8'd1, 16'h0000, 2, 16'h0002, 16'h0801);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
